// File: rtl/seq_channel_selector.sv
// seq_channel_selector
// Round-robin N-channel selector driven by a debounced push button.
// Each accepted press moves the selection to the next enabled channel.
// The selected channel's data is presented on a registered output.
// Disabled channels are skipped by the search. If the current channel
// becomes disabled, the output is forced to zero until a press moves on.
module seq_channel_selector #(
    parameter int  DATABUS_WIDTH   = 9,
    parameter int  NUM_CHANNELS    = 4,
    parameter int  DEBOUNCE_CYCLES = 4,
    localparam int SEL_WIDTH       = (NUM_CHANNELS > 2) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  toggleButton,
    input  logic [NUM_CHANNELS*DATABUS_WIDTH-1:0] dataIn,
    input  logic [NUM_CHANNELS-1:0]               chanEnable,
    output logic [DATABUS_WIDTH-1:0]              dataOut,
    output logic [SEL_WIDTH-1:0]                  selIdx,
    output logic                                  selValid,
    output logic                                  switched
);

    localparam int CNT_WIDTH = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_REL,     // stable released
        ST_WAIT_P,  // low seen, counting toward an accepted press
        ST_PRS,     // stable pressed
        ST_WAIT_R   // high seen, counting toward an accepted release
    } db_state_t;

    logic                     sync1, sync2;
    db_state_t                state, state_next;
    logic [CNT_WIDTH-1:0]     cnt, cnt_next;
    logic                     advance;
    logic                     found;
    logic [SEL_WIDTH-1:0]     target, cand, sel_next;
    logic [DATABUS_WIDTH-1:0] data_sel;

    // Two-flop synchroniser; idles at the released level.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= toggleButton;
            sync2 <= sync1;
        end
    end

    // Debounce FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_REL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Debounce next-state logic: a new level is accepted after DEBOUNCE_CYCLES equal samples.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_REL: begin
                if (!sync2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = ST_PRS;
                    end else begin
                        state_next = ST_WAIT_P;
                        cnt_next   = CNT_WIDTH'(1);
                    end
                end
            end
            ST_WAIT_P: begin
                if (sync2) begin
                    state_next = ST_REL;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_PRS;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            ST_PRS: begin
                if (sync2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = ST_REL;
                    end else begin
                        state_next = ST_WAIT_R;
                        cnt_next   = CNT_WIDTH'(1);
                    end
                end
            end
            ST_WAIT_R: begin
                if (!sync2) begin
                    state_next = ST_PRS;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_REL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_next = ST_REL;
                cnt_next   = '0;
            end
        endcase
    end

    // Debounce output: advance pulses on the single cycle that commits a press.
    always_comb begin
        advance = 1'b0;
        case (state)
            ST_REL:    advance = (DEBOUNCE_CYCLES == 1) && !sync2;
            ST_WAIT_P: advance = !sync2 && (cnt == CNT_LAST);
            default:   advance = 1'b0;
        endcase
    end

    // Find the first enabled channel after the current one, wrapping, excluding itself.
    always_comb begin
        found  = 1'b0;
        target = selIdx;
        cand   = '0;
        for (int k = 1; k < NUM_CHANNELS; k++) begin
            cand = SEL_WIDTH'((int'(selIdx) + k) % NUM_CHANNELS);
            if (!found && chanEnable[cand]) begin
                found  = 1'b1;
                target = cand;
            end
        end
    end

    // Selection after this edge, and the data bus it points at.
    always_comb begin
        sel_next = (advance && found) ? target : selIdx;
        data_sel = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (sel_next == SEL_WIDTH'(i)) begin
                data_sel = dataIn[i*DATABUS_WIDTH +: DATABUS_WIDTH];
            end
        end
    end

    // Output register: samples the updated selection so data tracks it on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            selIdx   <= '0;
            dataOut  <= '0;
            selValid <= 1'b0;
            switched <= 1'b0;
        end else begin
            selIdx   <= sel_next;
            switched <= advance && found;
            selValid <= chanEnable[sel_next];
            dataOut  <= chanEnable[sel_next] ? data_sel : '0;
        end
    end

endmodule

// File: tb/tb_seq_channel_selector.sv
// Bench for seq_channel_selector: a behavioural model checked every cycle,
// plus directed button scenarios with literal expectations.
module tb_seq_channel_selector;

    localparam int W = 9;
    localparam int N = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           toggleButton;
    logic [N*W-1:0] dataIn;
    logic [N-1:0]   chanEnable;
    logic [W-1:0]   dataOut;
    logic [1:0]     selIdx;
    logic           selValid;
    logic           switched;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_channel_selector #(
        .DATABUS_WIDTH   (W),
        .NUM_CHANNELS    (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .toggleButton (toggleButton),
        .dataIn       (dataIn),
        .chanEnable   (chanEnable),
        .dataOut      (dataOut),
        .selIdx       (selIdx),
        .selValid     (selValid),
        .switched     (switched)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a press is accepted once the synchronised button has
    // disagreed with the accepted level for D consecutive samples.
    logic         m_s1, m_s2, m_acc;
    int           m_run;
    int           m_sel;
    logic [W-1:0] m_data;
    logic         m_valid, m_sw;
    bit           chk_on = 0;

    always @(posedge clk) begin : model
        bit press_now;
        press_now = 0;
        if (rst) begin
            m_s1 = 1; m_s2 = 1; m_acc = 1; m_run = 0;
            m_sel = 0; m_data = '0; m_valid = 0; m_sw = 0;
            chk_on = 1;
        end else begin
            if (m_s2 != m_acc) begin
                m_run++;
                if (m_run == D) begin
                    m_acc = m_s2;
                    m_run = 0;
                    press_now = (m_acc == 1'b0);
                end
            end else begin
                m_run = 0;
            end
            m_sw = 0;
            if (press_now) begin
                for (int k = 1; k < N; k++) begin
                    int j;
                    j = (m_sel + k) % N;
                    if (chanEnable[j]) begin
                        m_sel = j;
                        m_sw  = 1;
                        break;
                    end
                end
            end
            m_valid = chanEnable[m_sel];
            m_data  = m_valid ? dataIn[m_sel*W +: W] : '0;
            m_s2 = m_s1;
            m_s1 = toggleButton;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_selIdx",   32'(selIdx),   32'(m_sel));
            check("cyc_dataOut",  32'(dataOut),  32'(m_data));
            check("cyc_selValid", 32'(selValid), 32'(m_valid));
            check("cyc_switched", 32'(switched), 32'(m_sw));
        end
    end

    // Called on a negedge: hold low for lo cycles, then high for hi cycles.
    // sw_at = negedge index (0 = after the sync1 capture edge) of the first switched pulse.
    task automatic press(input int lo, input int hi, output int sw_at, output int sw_cnt);
        sw_at  = -1;
        sw_cnt = 0;
        toggleButton = 1'b0;
        for (int k = 0; k < lo; k++) begin
            @(negedge clk);
            if (switched === 1'b1) begin
                sw_cnt++;
                if (sw_at < 0) sw_at = k;
            end
        end
        toggleButton = 1'b1;
        for (int k = 0; k < hi; k++) begin
            @(negedge clk);
            if (switched === 1'b1) sw_cnt++;
        end
    endtask

    task automatic run(input int n, inout int sw_cnt);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (switched === 1'b1) sw_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int at, cnt;
        logic [1:0] exp_sel  [4];
        logic [8:0] exp_data [4];
        exp_sel  = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_data = '{9'h022, 9'h033, 9'h044, 9'h011};

        rst          = 1'b1;
        toggleButton = 1'b1;
        chanEnable   = 4'b1111;
        dataIn       = {9'h044, 9'h033, 9'h022, 9'h011};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dataOut",  32'(dataOut),  32'h011);
        check("rst_selIdx",   32'(selIdx),   32'd0);
        check("rst_selValid", 32'(selValid), 32'd1);
        check("rst_switched", 32'(switched), 32'd0);

        // Four clean presses walk the ring.
        for (int p = 0; p < 4; p++) begin
            press(10, 10, at, cnt);
            check("clean_sw_latency", 32'(at),      32'(D + 1));
            check("clean_sw_count",   32'(cnt),     32'd1);
            check("clean_selIdx",     32'(selIdx),  32'(exp_sel[p]));
            check("clean_dataOut",    32'(dataOut), 32'(exp_data[p]));
        end

        // Bounce: short lows never accepted.
        cnt = 0;
        for (int b = 0; b < 5; b++) begin
            toggleButton = 1'b0;
            run(2, cnt);
            toggleButton = 1'b1;
            run(1, cnt);
        end
        run(10, cnt);
        check("bounce_sw_count", 32'(cnt),    32'd0);
        check("bounce_selIdx",   32'(selIdx), 32'd0);

        // Long hold: exactly one advance.
        press(100, 10, at, cnt);
        check("hold_sw_count", 32'(cnt),    32'd1);
        check("hold_selIdx",   32'(selIdx), 32'd1);

        // Mask 1010 from channel 1: 1 -> 3 -> 1.
        chanEnable = 4'b1010;
        press(10, 10, at, cnt);
        check("mask_a_selIdx",  32'(selIdx),  32'd3);
        check("mask_a_dataOut", 32'(dataOut), 32'h044);
        press(10, 10, at, cnt);
        check("mask_b_selIdx",  32'(selIdx),  32'd1);
        check("mask_b_dataOut", 32'(dataOut), 32'h022);

        // Only the current channel enabled: press does nothing.
        chanEnable = 4'b0010;
        press(10, 10, at, cnt);
        check("solo_selIdx",   32'(selIdx), 32'd1);
        check("solo_sw_count", 32'(cnt),    32'd0);

        // Disable the current channel at selIdx 2.
        chanEnable = 4'b1111;
        press(10, 10, at, cnt);
        check("to2_selIdx", 32'(selIdx), 32'd2);
        chanEnable = 4'b1011;
        @(negedge clk);
        check("dis_dataOut",  32'(dataOut),  32'h000);
        check("dis_selValid", 32'(selValid), 32'd0);
        check("dis_selIdx",   32'(selIdx),   32'd2);
        press(10, 10, at, cnt);
        check("dis_next_selIdx",  32'(selIdx),  32'd3);
        check("dis_next_dataOut", 32'(dataOut), 32'h044);

        // Data path: selected channel change visible one edge later.
        dataIn[3*W +: W] = 9'h1A5;
        @(negedge clk);
        check("data_follow", 32'(dataOut), 32'h1A5);

        // Reset in WAIT_P with count 2 aborts the press.
        toggleButton = 1'b0;
        repeat (4) @(negedge clk);
        rst          = 1'b1;
        toggleButton = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_selIdx",   32'(selIdx),   32'd0);
        check("mid_rst_dataOut",  32'(dataOut),  32'h011);
        check("mid_rst_selValid", 32'(selValid), 32'd1);
        cnt = 0;
        run(10, cnt);
        check("mid_rst_no_adv", 32'(cnt),    32'd0);
        check("mid_rst_hold",   32'(selIdx), 32'd0);
        press(10, 10, at, cnt);
        check("post_rst_latency", 32'(at),      32'(D + 1));
        check("post_rst_selIdx",  32'(selIdx),  32'd1);
        check("post_rst_dataOut", 32'(dataOut), 32'h022);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_channel_selector.md
# seq_channel_selector

Parametrised sequential multiplexer that forwards one of NUM_CHANNELS data buses to a registered output. A push button (asynchronous, active-low press) steps the selection through the channels in round-robin order, skipping channels disabled by a runtime mask. The button is synchronised and debounced inside the block. It is the N-channel, glitch-safe successor of the two-input toggle mux and sits between the input sources and the display/output path.

## Interface
- DATABUS_WIDTH, 9, width of each data channel
- NUM_CHANNELS, 4, number of input channels; legal range ≥ 2
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a button level; legal range ≥ 1
- Localparam SEL_WIDTH = max(1, clog2(NUM_CHANNELS))
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- toggleButton  in  1  asynchronous button; 1 = released, 0 = pressed
- dataIn  in  NUM_CHANNELS*DATABUS_WIDTH  flattened channels; channel i occupies bits [i*DATABUS_WIDTH +: DATABUS_WIDTH]
- chanEnable  in  NUM_CHANNELS  bit i = 1 makes channel i selectable
- dataOut  out  DATABUS_WIDTH  registered selected data
- selIdx  out  SEL_WIDTH  current channel index (registered)
- selValid  out  1  registered; 1 when chanEnable[selIdx] = 1
- switched  out  1  one-cycle pulse; 1 in the cycle after selIdx changed

## Operation
- Synchroniser: two flops, sync1 → sync2. Both reset to 1.
- Debounce FSM on sync2, with a counter in the range 0..DEBOUNCE_CYCLES-1:
  - REL (stable released): sync2 = 0 → WAIT_P with count 1 if DEBOUNCE_CYCLES > 1. If DEBOUNCE_CYCLES = 1, go straight to PRS and fire advance.
  - WAIT_P: sync2 = 1 → REL with count 0. sync2 = 0 and count = DEBOUNCE_CYCLES-1 → PRS and fire advance. Otherwise count increments.
  - PRS (stable pressed): sync2 = 1 → WAIT_R (or straight to REL when DEBOUNCE_CYCLES = 1).
  - WAIT_R: mirrors WAIT_P with the polarity inverted. Reaching REL fires nothing.
- advance is an internal one-cycle pulse. It fires once per accepted press; holding the button never repeats it.
- Next-channel search on advance:
  - Target is the first index j = selIdx+1, selIdx+2, … (mod NUM_CHANNELS, wrapping past NUM_CHANNELS-1 to 0) with chanEnable[j] = 1, excluding selIdx itself.
  - If no such j exists, selIdx holds and switched stays 0.
- Mask changes never move selIdx by themselves. If the current channel is disabled, selValid = 0 and dataOut = 0 until a press selects an enabled channel.
- Output register, every cycle:
  - dataOut <= chanEnable[selIdx] ? channel(selIdx) : 0
  - selValid <= chanEnable[selIdx]
  - Both use the selIdx value that applies after this edge's update.
- Reset values: sync1 = sync2 = 1, FSM = REL, count = 0, selIdx = 0, dataOut = 0, selValid = 0, switched = 0.
- rst asserted mid-debounce aborts the debounce. No advance fires and selection returns to channel 0.

## Timing
- Button press latency: let edge E be the first rising edge at which sync1 captures 0.
  - sync2 = 0 after E+1.
  - With the button held low, advance is high in the cycle following edge E+DEBOUNCE_CYCLES.
  - selIdx updates at edge E+DEBOUNCE_CYCLES+1.
  - dataOut and selValid reflect the new channel from that same edge, because the output register samples the updated selection.
  - switched is high for the one cycle after edge E+DEBOUNCE_CYCLES+1.
- Bounce: any sync2 glitch shorter than DEBOUNCE_CYCLES samples produces no advance.
- Data path: a change on dataIn of the selected channel appears on dataOut one edge later.
- After rst deasserts: dataOut = channel 0 (or 0 if disabled) from the first edge.

## Test plan
- Reset, mask 4'b1111, dataIn ch0..3 = 9'h011/022/033/044: dataOut = 9'h011, selIdx = 0, selValid = 1.
- Four clean presses (low 10 cycles, high 10 cycles, DEBOUNCE_CYCLES = 4) -> selIdx steps 1, 2, 3, 0. dataOut follows 9'h022, 9'h033, 9'h044, 9'h011. Exactly one switched pulse per press at latency DEBOUNCE_CYCLES+1 from the sync1 capture edge.
- Bounce: low for 2 cycles, high for 1, repeated 5×, then released -> no selIdx change, switched never asserted. Holding low for 100 cycles -> exactly one advance.
- Mask 4'b1010 from selIdx 1 -> one press gives selIdx 3, next press gives 1 (wrap with skip). Mask 4'b0010 -> a press leaves selIdx 1 and switched = 0.
- With selIdx = 2, clear chanEnable[2] -> next cycle dataOut = 0, selValid = 0, selIdx stays 2. A press then selects the next enabled channel.
- Assert rst while in WAIT_P with count = 2 -> no advance; selIdx = 0, dataOut = channel 0, FSM = REL. A press after release steps to channel 1 normally.
